apb_textbuf_writer: RTL and testbench
=====================================

// Module: apb_textbuf_writer
// PURPOSE
//  APB3 completer that owns the write/host side of the 80x60 character text buffer.
//  Translates CPU accesses into single-port RAM cycles: direct cell R/W, cursor-indexed
//  auto-increment writes, and a hardware screen-fill engine.
//  Shares the RAM port with the VGA scan reader; the scanner always wins (scan_req).
// PARAMETERS
//  CHARACTER_SET_COUNT  20  glyph count; CH_W = $clog2(CHARACTER_SET_COUNT)
//  COLS                 80  text columns
//  ROWS                 60  text rows; CELLS = COLS*ROWS, A_W = $clog2(CELLS)
//  APB_ADDR_W           16  paddr width (>=16)
// PORTS
//  clk        in   1           system clock
//  rstn       in   1           async active-low reset
//  psel       in   1           APB select
//  penable    in   1           APB access phase
//  pwrite     in   1           1=write
//  paddr      in   APB_ADDR_W  byte address; [1:0] ignored
//  pwdata     in   32          write data
//  prdata     out  32          read data, zero-extended
//  pready     out  1           transfer complete
//  pslverr    out  1           error, valid only with pready
//  scan_req   in   1           scanner owns RAM port this cycle
//  buf_en     out  1           RAM enable (only when scan_req=0)
//  buf_we     out  1           RAM write enable
//  buf_addr   out  A_W         RAM cell index
//  buf_wdata  out  CH_W        RAM write data
//  buf_rdata  in   CH_W        RAM registered read data (1-cycle latency)
//  busy       out  1           fill in progress
// BEHAVIOUR
//  Reset: prdata=0, pready=0, pslverr=0, buf_en=0, buf_we=0, buf_addr=0, buf_wdata=0,
//   busy=0, cursor=0, FSM=IDLE. Reset mid-transfer/mid-fill aborts; no further RAM cycles.
//  Map: paddr[15]=0 -> cell window, index=paddr[14:2]; index>=CELLS -> pslverr.
//   0x8000 CURSOR RW [A_W-1:0]; write value>=CELLS -> pslverr, cursor unchanged.
//   0x8004 DATA: write -> RAM[cursor]=pwdata[CH_W-1:0], cursor=(cursor==CELLS-1)?0:cursor+1;
//          read -> RAM[cursor], no increment.  0x8008 FILL: write starts fill with
//          pwdata[CH_W-1:0]; read returns {31'b0,busy}. Other paddr[15]=1 -> pslverr.
//  FSM: IDLE -> (psel&penable) decode; RAM op -> ACCESS, else -> DONE.
//   ACCESS: issue buf_en (+buf_we) in first cycle with scan_req=0; write -> DONE,
//   read -> RDWAIT. RDWAIT: capture buf_rdata -> DONE. DONE: pready=1 one cycle -> IDLE.
//   FILL: one write per scan_req=0 cycle, addr 0..CELLS-1, then busy=0 -> IDLE-capable.
//  Latency, no contention: reg/error 1 wait state; RAM write 1; RAM read 2.
//   Each scan_req=1 cycle in ACCESS/FILL adds one cycle; no timeout.
//  Fill runs in background; APB handled in parallel: CURSOR and FILL read allowed;
//   cell window, DATA and FILL write while busy -> pslverr, no side effect.
//  pwdata bits above CH_W ignored; prdata bits above CH_W/A_W zero.
//  Fill write issued the same cycle busy rises is impossible: FILL write completes in DONE,
//   engine starts the cycle after. Cursor unaffected by fill.
//  buf_en never asserted while scan_req=1; buf_we=0 whenever buf_en=0.
// STRUCTURE
//  Package textbuf_pkg: COLS/ROWS/CELLS, A_W/CH_W functions, register offsets
//   (REG_CURSOR, REG_DATA, REG_FILL), FSM state enum.
//  Sub-module textbuf_fill_engine: counter + done flag; owner FSM muxes its port
//   requests against the APB ACCESS request (APB access wins when both pending).
// TESTING
//  Write 0x0000_0013 to 0x0010 (cell 4), scan_req=0 -> buf_en,buf_we,addr=4,wdata=19; pready 1 wait.
//  Read 0x0010 with scan_req high 3 cycles -> no buf_en while high; prdata=19, 5 wait states.
//  CURSOR=4799, DATA write 7 twice -> RAM[4799]=7, RAM[0]=7, CURSOR reads 1.
//  Access 0x4B00 (cell 4800) and 0x800C -> pslverr=1, pready=1, no buf_en.
//  FILL=5 -> busy 4800 cycles (scan_req=0); cell write during busy -> pslverr; CURSOR R/W OK.
//  Deassert rstn mid-fill at cell 100 -> busy=0, buf_en=0 immediately; all outputs reset.

Source files
------------

// File: rtl/textbuf_pkg.sv
// Shared constants, width helpers, register offsets and FSM state type for the
// text-buffer write side.
package textbuf_pkg;

  localparam int DEF_CHARSET = 20;
  localparam int DEF_COLS    = 80;
  localparam int DEF_ROWS    = 60;
  localparam int DEF_CELLS   = DEF_COLS * DEF_ROWS;

  // Byte offsets of the control registers (paddr[15] = 1 selects this window)
  localparam logic [15:0] REG_CURSOR = 16'h8000;
  localparam logic [15:0] REG_DATA   = 16'h8004;
  localparam logic [15:0] REG_FILL   = 16'h8008;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RDWAIT,
    ST_DONE
  } state_e;

  function automatic int addr_width(input int cols, input int rows);
    return $clog2(cols * rows);
  endfunction

  function automatic int char_width(input int count);
    return $clog2(count);
  endfunction

endpackage

// File: rtl/textbuf_fill_engine.sv
// Background screen-fill engine: walks every cell once, writing one glyph per
// granted RAM cycle, then drops busy.
module textbuf_fill_engine #(
  parameter int A_W   = 13,
  parameter int CH_W  = 5,
  parameter int CELLS = 4800
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start_i,
  input  logic [CH_W-1:0] char_i,
  input  logic            grant_i,
  output logic            busy_o,
  output logic [A_W-1:0]  addr_o,
  output logic [CH_W-1:0] wdata_o
);

  logic            busy_q;
  logic [A_W-1:0]  cnt_q;
  logic [CH_W-1:0] char_q;
  logic            last_cell;

  assign last_cell = (cnt_q == A_W'(CELLS - 1));

  // Load on start, advance one cell per granted cycle, finish after the last cell.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      char_q <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      char_q <= char_i;
    end else if (busy_q && grant_i) begin
      if (last_cell) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + A_W'(1);
      end
    end
  end

  assign busy_o  = busy_q;
  assign addr_o  = cnt_q;
  assign wdata_o = char_q;

endmodule

// File: rtl/apb_textbuf_writer.sv
// APB3 completer owning the write side of the character text buffer: direct
// cell access, cursor auto-increment DATA port and a background fill engine,
// all sharing one RAM port that the VGA scanner can claim every cycle.
module apb_textbuf_writer
  import textbuf_pkg::*;
#(
  parameter int CHARACTER_SET_COUNT = DEF_CHARSET,
  parameter int COLS                = DEF_COLS,
  parameter int ROWS                = DEF_ROWS,
  parameter int APB_ADDR_W          = 16,
  parameter int CELLS               = COLS * ROWS,
  parameter int A_W                 = addr_width(COLS, ROWS),
  parameter int CH_W                = char_width(CHARACTER_SET_COUNT)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  scan_req,
  output logic                  buf_en,
  output logic                  buf_we,
  output logic [A_W-1:0]        buf_addr,
  output logic [CH_W-1:0]       buf_wdata,
  input  logic [CH_W-1:0]       buf_rdata,
  output logic                  busy
);

  state_e          state_q;
  logic [31:0]     prdata_q;
  logic            pready_q;
  logic            pslverr_q;
  logic [A_W-1:0]  cursor_q;
  logic [A_W-1:0]  addr_q;
  logic [CH_W-1:0] wdata_q;
  logic            we_q;
  logic            data_q;
  logic            fill_pend_q;

  logic            fill_busy;
  logic [A_W-1:0]  fill_addr;
  logic [CH_W-1:0] fill_wdata;
  logic            fill_start;
  logic            fill_grant;

  // Address decode of the current APB request
  logic [12:0]     cell_idx;
  logic            is_reg;
  logic            sel_cur;
  logic            sel_data;
  logic            sel_fill;
  logic            cell_ok;
  logic            cur_val_ok;
  logic            dec_ram;
  logic            dec_err;
  logic            apb_start;
  logic            apb_req;
  logic            apb_we;
  logic            apb_grant;
  logic [A_W-1:0]  next_cursor;
  logic            unused_bits;

  assign cell_idx    = paddr[14:2];
  assign is_reg      = paddr[15];
  assign sel_cur     = is_reg && (paddr[14:2] == REG_CURSOR[14:2]);
  assign sel_data    = is_reg && (paddr[14:2] == REG_DATA[14:2]);
  assign sel_fill    = is_reg && (paddr[14:2] == REG_FILL[14:2]);
  assign cell_ok     = ({19'd0, cell_idx} < 32'(CELLS));
  assign cur_val_ok  = (32'(pwdata[A_W-1:0]) < 32'(CELLS));
  assign next_cursor = (cursor_q == A_W'(CELLS - 1)) ? '0 : cursor_q + A_W'(1);
  assign unused_bits = ^{paddr, pwdata};

  // Classify the request: RAM operation, register access or error.
  // NOTE: every output gets a default first so no path leaves a value held,
  // which would otherwise infer a latch.
  always_comb begin
    dec_ram = 1'b0;
    dec_err = 1'b0;
    if (!is_reg) begin
      dec_ram = cell_ok && !fill_busy;
      dec_err = !cell_ok || fill_busy;
    end else if (sel_data) begin
      dec_ram = !fill_busy;
      dec_err = fill_busy;
    end else if (sel_cur) begin
      dec_err = pwrite && !cur_val_ok;
    end else if (sel_fill) begin
      dec_err = pwrite && fill_busy;
    end else begin
      dec_err = 1'b1;
    end
  end

  // RAM port arbitration: scanner first, then the CPU access, then the fill engine
  assign apb_start  = (state_q == ST_IDLE) && psel && penable;
  assign apb_req    = (apb_start && dec_ram) || (state_q == ST_ACCESS);
  assign apb_we     = (state_q == ST_ACCESS) ? we_q : pwrite;
  assign apb_grant  = apb_req && !scan_req;
  assign fill_grant = fill_busy && !apb_req && !scan_req;
  assign fill_start = (state_q == ST_DONE) && fill_pend_q;

  assign buf_en    = apb_grant || fill_grant;
  assign buf_we    = (apb_grant && apb_we) || fill_grant;
  assign buf_addr  = apb_req ? addr_q : fill_addr;
  assign buf_wdata = apb_req ? wdata_q : fill_wdata;

  textbuf_fill_engine #(
    .A_W   (A_W),
    .CH_W  (CH_W),
    .CELLS (CELLS)
  ) u_fill (
    .clk     (clk),
    .rstn    (rstn),
    .start_i (fill_start),
    .char_i  (wdata_q),
    .grant_i (fill_grant),
    .busy_o  (fill_busy),
    .addr_o  (fill_addr),
    .wdata_o (fill_wdata)
  );

  // Owner FSM: decodes transfers, completes RAM cycles, registers the APB response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      cursor_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      data_q      <= 1'b0;
      fill_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Setup phase captures the RAM target so the access phase can issue at once
          if (psel) begin
            addr_q  <= is_reg ? cursor_q : A_W'(cell_idx);
            wdata_q <= pwdata[CH_W-1:0];
          end
          if (apb_start) begin
            we_q     <= pwrite;
            data_q   <= is_reg;
            prdata_q <= '0;
            if (dec_err) begin
              pslverr_q <= 1'b1;
              pready_q  <= 1'b1;
              state_q   <= ST_DONE;
            end else if (dec_ram) begin
              if (scan_req) begin
                state_q <= ST_ACCESS;
              end else if (pwrite) begin
                if (is_reg) cursor_q <= next_cursor;
                pready_q <= 1'b1;
                state_q  <= ST_DONE;
              end else begin
                state_q <= ST_RDWAIT;
              end
            end else begin
              pready_q <= 1'b1;
              state_q  <= ST_DONE;
              if (sel_cur) begin
                if (pwrite) cursor_q <= pwdata[A_W-1:0];
                else        prdata_q <= 32'(cursor_q);
              end else begin
                if (pwrite) fill_pend_q <= 1'b1;
                else        prdata_q    <= 32'(fill_busy);
              end
            end
          end
        end
        ST_ACCESS: begin
          if (!scan_req) begin
            if (we_q) begin
              if (data_q) cursor_q <= next_cursor;
              pready_q <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              state_q <= ST_RDWAIT;
            end
          end
        end
        ST_RDWAIT: begin
          prdata_q <= 32'(buf_rdata);
          pready_q <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          pready_q    <= 1'b0;
          pslverr_q   <= 1'b0;
          fill_pend_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign busy    = fill_busy;

endmodule

// File: tb/tb_apb_textbuf_writer.sv
// Self-checking bench for apb_textbuf_writer: APB responses and RAM writes are
// predicted into queues and compared as the DUT produces them.
module tb_apb_textbuf_writer;

  localparam int CELLS = 4800;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        scan_req = 1'b0;
  logic        buf_en;
  logic        buf_we;
  logic [12:0] buf_addr;
  logic [4:0]  buf_wdata;
  logic [4:0]  buf_rdata;
  logic        busy;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rd;
    logic        err;
    int          waits;
  } apb_exp_t;

  typedef struct {
    logic [12:0] addr;
    logic [4:0]  data;
  } wr_exp_t;

  apb_exp_t apb_q[$];
  wr_exp_t  wr_q[$];
  int       n_total = 0;
  int       n_bad = 0;
  int       en_cnt = 0;

  logic [4:0] mem [CELLS];

  always #5 clk = ~clk;

  apb_textbuf_writer dut (
    .clk       (clk),
    .rstn      (rstn),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .scan_req  (scan_req),
    .buf_en    (buf_en),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .buf_wdata (buf_wdata),
    .buf_rdata (buf_rdata),
    .busy      (busy)
  );

  // Single-port RAM with registered read
  always @(posedge clk) begin
    if (buf_en) begin
      if (buf_we) mem[buf_addr] <= buf_wdata;
      else        buf_rdata     <= mem[buf_addr];
    end
  end

  // RAM port monitor: checks port rules and pops expected writes
  initial begin
    wr_exp_t e;
    forever begin
      @(negedge clk);
      if (buf_en === 1'b1) en_cnt++;
      if (scan_req) begin
        n_total++;
        if (buf_en !== 1'b0) begin
          n_bad++;
          $display("FAIL port_yield: buf_en=%b while scan_req=1 (need 0)", buf_en);
        end
      end
      if (buf_en === 1'b1 && buf_we === 1'b1) begin
        n_total++;
        if (wr_q.size() == 0) begin
          n_bad++;
          $display("FAIL ram_write: unexpected write addr=%0d data=%0d", buf_addr, buf_wdata);
        end else begin
          e = wr_q.pop_front();
          if (buf_addr !== e.addr || buf_wdata !== e.data) begin
            n_bad++;
            $display("FAIL ram_write: got addr=%0d data=%0d, want addr=%0d data=%0d",
                     buf_addr, buf_wdata, e.addr, e.data);
          end
        end
      end else if (buf_en !== 1'b1 && buf_we !== 1'b0) begin
        n_total++;
        n_bad++;
        $display("FAIL we_gating: buf_we=%b with buf_en=%b", buf_we, buf_en);
      end
    end
  end

  task automatic exp_apb(input logic [31:0] rd, input logic chk, input logic err, input int w);
    apb_exp_t e;
    e.rdata = rd; e.chk_rd = chk; e.err = err; e.waits = w;
    apb_q.push_back(e);
  endtask

  task automatic exp_wr(input int a, input int d);
    wr_exp_t e;
    e.addr = 13'(a); e.data = 5'(d);
    wr_q.push_back(e);
  endtask

  // APB master; compares the response against the front of the APB scoreboard
  task automatic apb_xfer(input string name, input logic wr, input logic [15:0] addr,
                          input logic [31:0] wdata, input int nscan);
    apb_exp_t    e;
    int          waits;
    logic        done;
    logic [31:0] rd;
    logic        err;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1; scan_req = (nscan > 0);
    waits = 0; done = 1'b0; rd = '0; err = 1'b0;
    while (!done && waits < 64) begin
      @(negedge clk);
      if (pready === 1'b1) begin
        done = 1'b1; rd = prdata; err = pslverr;
      end else begin
        waits++;
        @(posedge clk); #1;
        if (waits >= nscan) scan_req = 1'b0;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; scan_req = 1'b0;
    e = apb_q.pop_front();
    n_total++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s: pready never rose within %0d cycles", name, waits);
    end else begin
      if (err !== e.err) begin
        n_bad++;
        $display("FAIL %s: pslverr=%b, want %b", name, err, e.err);
      end
      n_total++;
      if (waits != e.waits) begin
        n_bad++;
        $display("FAIL %s: wait states=%0d, want %0d", name, waits, e.waits);
      end
      if (e.chk_rd) begin
        n_total++;
        if (rd !== e.rdata) begin
          n_bad++;
          $display("FAIL %s: prdata=0x%08h, want 0x%08h", name, rd, e.rdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({prdata, pready, pslverr, buf_en, buf_we, buf_addr, buf_wdata, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: prdata=%h pready=%b pslverr=%b en=%b we=%b addr=%0d wdata=%0d busy=%b, want all 0",
               prdata, pready, pslverr, buf_en, buf_we, buf_addr, buf_wdata, busy);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_apb(32'd0, 1'b1, 1'b0, 1); apb_xfer("reset_cursor", 1'b0, 16'h8000, 32'd0, 0);
    exp_apb(32'd0, 1'b1, 1'b0, 1); apb_xfer("reset_busy", 1'b0, 16'h8008, 32'd0, 0);
  endtask

  task automatic test_cell_write();
    exp_wr(4, 19);
    exp_apb(32'd0, 1'b0, 1'b0, 1); apb_xfer("cell4_write", 1'b1, 16'h0010, 32'h0000_0013, 0);
    exp_wr(5, 9);
    exp_apb(32'd0, 1'b0, 1'b0, 1); apb_xfer("cell5_write_hi", 1'b1, 16'h0014, 32'hFFFF_FFE9, 0);
  endtask

  task automatic test_read_contention();
    exp_apb(32'd19, 1'b1, 1'b0, 5); apb_xfer("cell4_read_scan", 1'b0, 16'h0010, 32'd0, 3);
    exp_apb(32'd9, 1'b1, 1'b0, 2);  apb_xfer("cell5_read", 1'b0, 16'h0014, 32'd0, 0);
  endtask

  task automatic test_cursor_wrap();
    exp_apb(32'd0, 1'b0, 1'b0, 1); apb_xfer("cursor_set_last", 1'b1, 16'h8000, 32'd4799, 0);
    exp_wr(4799, 7);
    exp_apb(32'd0, 1'b0, 1'b0, 1); apb_xfer("data_write_last", 1'b1, 16'h8004, 32'd7, 0);
    exp_wr(0, 7);
    exp_apb(32'd0, 1'b0, 1'b0, 1); apb_xfer("data_write_wrap", 1'b1, 16'h8004, 32'd7, 0);
    exp_apb(32'd1, 1'b1, 1'b0, 1); apb_xfer("cursor_after_wrap", 1'b0, 16'h8000, 32'd0, 0);
    exp_apb(32'd0, 1'b0, 1'b1, 1); apb_xfer("cursor_set_4800", 1'b1, 16'h8000, 32'd4800, 0);
    exp_apb(32'd1, 1'b1, 1'b0, 1); apb_xfer("cursor_unchanged", 1'b0, 16'h8000, 32'd0, 0);
    exp_apb(32'd0, 1'b0, 1'b0, 1); apb_xfer("cursor_set_0", 1'b1, 16'h8000, 32'd0, 0);
    exp_apb(32'd7, 1'b1, 1'b0, 2); apb_xfer("data_read", 1'b0, 16'h8004, 32'd0, 0);
    exp_apb(32'd0, 1'b1, 1'b0, 1); apb_xfer("cursor_no_incr", 1'b0, 16'h8000, 32'd0, 0);
  endtask

  task automatic test_errors();
    int en_before;
    exp_apb(32'd7, 1'b1, 1'b0, 2); apb_xfer("cell4799_read", 1'b0, 16'h4AFC, 32'd0, 0);
    en_before = en_cnt;
    exp_apb(32'd0, 1'b0, 1'b1, 1); apb_xfer("cell4800_read", 1'b0, 16'h4B00, 32'd0, 0);
    exp_apb(32'd0, 1'b0, 1'b1, 1); apb_xfer("cell4800_write", 1'b1, 16'h4B00, 32'd3, 0);
    exp_apb(32'd0, 1'b0, 1'b1, 1); apb_xfer("reg800c_read", 1'b0, 16'h800C, 32'd0, 0);
    exp_apb(32'd0, 1'b0, 1'b1, 1); apb_xfer("reg800c_write", 1'b1, 16'h800C, 32'd3, 0);
    n_total++;
    if (en_cnt != en_before) begin
      n_bad++;
      $display("FAIL error_no_ram: buf_en cycles=%0d, want 0", en_cnt - en_before);
    end
  endtask

  task automatic test_fill();
    int busy_cycles;
    for (int i = 0; i < CELLS; i++) exp_wr(i, 5);
    exp_apb(32'd0, 1'b0, 1'b0, 1); apb_xfer("fill_start", 1'b1, 16'h8008, 32'd5, 0);
    busy_cycles = 0;
    fork
      begin
        while (busy === 1'b1 && busy_cycles < 6000) begin
          @(negedge clk);
          if (busy === 1'b1) busy_cycles++;
        end
      end
      begin
        exp_apb(32'd0, 1'b0, 1'b1, 1); apb_xfer("busy_cell_write", 1'b1, 16'h0010, 32'd1, 0);
        exp_apb(32'd0, 1'b0, 1'b1, 1); apb_xfer("busy_data_write", 1'b1, 16'h8004, 32'd1, 0);
        exp_apb(32'd0, 1'b0, 1'b1, 1); apb_xfer("busy_fill_write", 1'b1, 16'h8008, 32'd9, 0);
        exp_apb(32'd0, 1'b0, 1'b0, 1); apb_xfer("busy_cursor_write", 1'b1, 16'h8000, 32'd10, 0);
        exp_apb(32'd10, 1'b1, 1'b0, 1); apb_xfer("busy_cursor_read", 1'b0, 16'h8000, 32'd0, 0);
        exp_apb(32'd1, 1'b1, 1'b0, 1); apb_xfer("busy_flag_read", 1'b0, 16'h8008, 32'd0, 0);
      end
    join
    n_total++;
    if (busy_cycles != CELLS) begin
      n_bad++;
      $display("FAIL fill_busy_len: busy cycles=%0d, want %0d", busy_cycles, CELLS);
    end
    exp_apb(32'd0, 1'b1, 1'b0, 1); apb_xfer("fill_done_flag", 1'b0, 16'h8008, 32'd0, 0);
    n_total++;
    if (wr_q.size() != 0) begin
      n_bad++;
      $display("FAIL fill_writes: %0d fill writes never seen, want 0", wr_q.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    int cyc;
    int en_before;
    logic [4:0] m99;
    logic [4:0] m100;
    for (int i = 0; i < 100; i++) exp_wr(i, 3);
    exp_apb(32'd0, 1'b0, 1'b0, 1); apb_xfer("fill2_start", 1'b1, 16'h8008, 32'd3, 0);
    cyc = 0;
    while (wr_q.size() != 0 && cyc < 500) begin
      @(negedge clk); #1;
      cyc++;
    end
    n_total++;
    if (wr_q.size() != 0) begin
      n_bad++;
      $display("FAIL fill2_progress: %0d writes outstanding after %0d cycles, want 0", wr_q.size(), cyc);
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    n_total++;
    if ({prdata, pready, pslverr, buf_en, buf_we, buf_addr, buf_wdata, busy} !== '0) begin
      n_bad++;
      $display("FAIL midfill_reset: prdata=%h pready=%b pslverr=%b en=%b we=%b addr=%0d wdata=%0d busy=%b, want all 0",
               prdata, pready, pslverr, buf_en, buf_we, buf_addr, buf_wdata, busy);
    end
    en_before = en_cnt;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    m99 = mem[99];
    m100 = mem[100];
    n_total++;
    if (en_cnt != en_before || m99 !== 5'd3 || m100 !== 5'd5) begin
      n_bad++;
      $display("FAIL midfill_abort: en cycles=%0d mem99=%0d mem100=%0d, want 0 3 5",
               en_cnt - en_before, m99, m100);
    end
    exp_apb(32'd0, 1'b1, 1'b0, 1); apb_xfer("post_reset_cursor", 1'b0, 16'h8000, 32'd0, 0);
    exp_apb(32'd0, 1'b1, 1'b0, 1); apb_xfer("post_reset_busy", 1'b0, 16'h8008, 32'd0, 0);
  endtask

  initial begin
    test_reset();
    test_cell_write();
    test_read_contention();
    test_cursor_wrap();
    test_errors();
    test_fill();
    test_reset_mid_fill();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
